// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared constants and types for the pipelined carry-lookahead adder.
//   CLA_GROUP  : bit width of one lookahead group.
//   MAX_STAGES : largest supported pipeline depth.
//   flag_t     : result flags that travel with the sum.
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int CLA_GROUP  = 4;
    localparam int MAX_STAGES = 4;

    typedef struct packed {
        logic cout;  // carry out of the MSB (1 = no borrow when subtracting)
        logic ovf;   // signed overflow
        logic zero;  // final s == 0
        logic neg;   // final s[MSB]
    } flag_t;

endpackage

// File: rtl/cla_group4.sv
// ---------------------------------------------------------------------------
// cla_group4
//   One 4-bit carry-lookahead group. All internal carries come straight from
//   generate/propagate terms, so there is no ripple inside the group. Group
//   propagate/generate let the caller chain groups with a single AND-OR each.
//
// Ports
//   i_a, i_b : 4-bit operand nibbles (i_b already inverted for subtraction)
//   i_c      : carry into bit 0 of the group
//   o_s      : 4-bit sum
//   o_p      : group propagate (carry in passes through the whole group)
//   o_g      : group generate  (group produces a carry on its own)
// ---------------------------------------------------------------------------
module cla_group4
    import adder_pkg::*;
(
    input  logic [CLA_GROUP-1:0] i_a,
    input  logic [CLA_GROUP-1:0] i_b,
    input  logic                 i_c,
    output logic [CLA_GROUP-1:0] o_s,
    output logic                 o_p,
    output logic                 o_g
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;  // carry into each bit

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_s = w_p ^ w_c;
    assign o_p = &w_p;
    assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// pipe_cla_adder
//   Pipelined add/subtract unit. The operand is split into STAGES slices;
//   slice k is added in pipeline stage k from 4-bit lookahead groups, and its
//   carry-out is registered into stage k+1. Upper operand slices ride along
//   (skewed) until their stage; finished lower sum slices ride along
//   (delayed) so the whole word lands in the output register together.
//   Latency is STAGES cycles, throughput one operation per cycle.
//
// Handshake: an input transfer happens on a rising edge where
//   in_valid && in_ready; an output transfer where out_valid && out_ready.
//   The whole pipe moves together on advance = out_ready || !out_valid, and
//   in_ready equals advance, so a stalled output freezes every stage.
//
// Parameters
//   WIDTH  : operand/sum width, multiple of 4*STAGES (default 32)
//   STAGES : pipeline depth 1..4 (default 2)
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake
//   a, b                : operands
//   cin                 : carry-in for addition (ignored when sub=1)
//   sub                 : 1 = a-b, 0 = a+b+cin
//   sat                 : clamp on signed overflow (only with ADDER_SAT_EN)
//   out_valid/out_ready : output handshake
//   s                   : result
//   cout, ovf, zero, neg: result flags
//
// Build option: define ADDER_SAT_EN to add the sat port and clamp logic.
// ---------------------------------------------------------------------------
module pipe_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SW  = WIDTH / STAGES;   // bits added per stage
    localparam int GPS = SW / CLA_GROUP;   // lookahead groups per stage

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("pipe_cla_adder: STAGES must be in 1..MAX_STAGES");
    end
    if (WIDTH % (CLA_GROUP * STAGES) != 0) begin : g_bad_width
        $error("pipe_cla_adder: WIDTH must be a multiple of 4*STAGES");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_in;

    // Final-stage combinational result, driven from inside the last stage.
    logic             w_fin_valid;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_cout;
    logic             w_fin_ovf;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    flag_t            r_flags;

    assign w_adv    = out_ready | ~r_out_valid;
    assign in_ready = w_adv;

    // Subtraction is a + ~b + 1; cin only matters for addition.
    assign w_b_eff = sub ? ~b : b;
    assign w_c_in  = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k * SW;  // operand bits not yet added

        logic [REM-1:0] w_fa;
        logic [REM-1:0] w_fb;
        logic           w_ci;
        logic           w_vin;
`ifdef ADDER_SAT_EN
        logic           w_sat;
`endif
        logic [SW-1:0]  w_ss;
        logic [GPS:0]   w_gc;
        logic [GPS-1:0] w_gp;
        logic [GPS-1:0] w_gg;

        // Stage inputs: the ports for stage 0, the previous stage's skew
        // registers otherwise.
        if (k == 0) begin : g_src
            assign w_fa  = a;
            assign w_fb  = w_b_eff;
            assign w_ci  = w_c_in;
            assign w_vin = in_valid;
`ifdef ADDER_SAT_EN
            assign w_sat = sat;
`endif
        end else begin : g_src
            assign w_fa  = g_stage[k-1].g_reg.r_a;
            assign w_fb  = g_stage[k-1].g_reg.r_b;
            assign w_ci  = g_stage[k-1].g_reg.r_carry;
            assign w_vin = g_stage[k-1].g_reg.r_valid;
`ifdef ADDER_SAT_EN
            assign w_sat = g_stage[k-1].g_reg.r_sat;
`endif
        end

        // Slice adder: lookahead inside each group, group P/G chains groups.
        assign w_gc[0] = w_ci;
        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla_group4 u_grp (
                .i_a (w_fa[j*CLA_GROUP +: CLA_GROUP]),
                .i_b (w_fb[j*CLA_GROUP +: CLA_GROUP]),
                .i_c (w_gc[j]),
                .o_s (w_ss[j*CLA_GROUP +: CLA_GROUP]),
                .o_p (w_gp[j]),
                .o_g (w_gg[j])
            );
            assign w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
        end

        if (k < STAGES - 1) begin : g_reg
            logic                  r_valid;
            logic                  r_carry;
            logic [(k+1)*SW-1:0]   r_lo;   // finished low sum bits
            logic [REM-SW-1:0]     r_a;    // operand bits for later stages
            logic [REM-SW-1:0]     r_b;
`ifdef ADDER_SAT_EN
            logic                  r_sat;
`endif
            logic [(k+1)*SW-1:0]   w_lo_next;

            if (k == 0) begin : g_lo
                assign w_lo_next = w_ss;
            end else begin : g_lo
                assign w_lo_next = {w_ss, g_stage[k-1].g_reg.r_lo};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                end else if (w_adv) begin
                    r_valid <= w_vin;
                end
                if (w_adv) begin
                    r_carry <= w_gc[GPS];
                    r_lo    <= w_lo_next;
                    r_a     <= w_fa[REM-1:SW];
                    r_b     <= w_fb[REM-1:SW];
`ifdef ADDER_SAT_EN
                    r_sat   <= w_sat;
`endif
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] w_full;
            logic [WIDTH-1:0] w_res;
            logic             w_cout;
            logic             w_ovf;

            if (k == 0) begin : g_lo
                assign w_full = w_ss;
            end else begin : g_lo
                assign w_full = {w_ss, g_stage[k-1].g_reg.r_lo};
            end

            assign w_cout = w_gc[GPS];
            // Sum bit = a ^ b ^ carry-in, so the carry into the MSB is
            // recovered from the MSB sum bit and its operand bits.
            assign w_ovf  = w_cout ^ (w_full[WIDTH-1] ^ w_fa[SW-1] ^ w_fb[SW-1]);

`ifdef ADDER_SAT_EN
            localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
            localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
            // A wrapped result with MSB set means the true value was too
            // large (positive overflow), and vice versa.
            assign w_res = (w_sat && w_ovf) ? (w_full[WIDTH-1] ? SAT_MAX : SAT_MIN)
                                            : w_full;
`else
            assign w_res = w_full;
`endif

            assign w_fin_valid = w_vin;
            assign w_fin_res   = w_res;
            assign w_fin_cout  = w_cout;
            assign w_fin_ovf   = w_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_flags     <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_fin_valid;
            r_s         <= w_fin_res;
            r_flags     <= '{cout: w_fin_cout,
                             ovf:  w_fin_ovf,
                             zero: (w_fin_res == '0),
                             neg:  w_fin_res[WIDTH-1]};
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_flags.cout;
    assign ovf       = r_flags.ovf;
    assign zero      = r_flags.zero;
    assign neg       = r_flags.neg;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_cla_adder
//   Bench for pipe_cla_adder (WIDTH=32, STAGES=2). A reference model computes
//   each result with plain integer arithmetic; a negedge compare process
//   holds an expected queue and checks every cycle the output is valid.
//   Directed cases pin the model and the DUT to hand-computed values.
//   Define ADDER_SAT_EN to also exercise the saturation option.
// ---------------------------------------------------------------------------
module tb_pipe_cla_adder;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int EW = W + 4;  // {s, cout, ovf, zero, neg}

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    always #5 clk = ~clk;

    pipe_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef ADDER_SAT_EN
        .sat       (sat_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact signed/unsigned integer results, then wrap or clamp.
    function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                            input logic mcin, input logic msub, input logic msat);
        longint          sa, sb, full, max_s, min_s;
        longint unsigned ua, ub, usum;
        logic [W-1:0]    res;
        logic            c, v;
        max_s = 2147483647;
        min_s = -max_s - 1;
        sa = $signed(ma);
        sb = $signed(mb);
        ua = ma;
        ub = mb;
        if (msub) begin
            full = sa - sb;
            usum = ua - ub;
            c    = (ua >= ub);
        end else begin
            full = sa + sb + (mcin ? 1 : 0);
            usum = ua + ub + (mcin ? 64'd1 : 64'd0);
            c    = usum[32];
        end
        res = usum[W-1:0];
        v   = (full > max_s) || (full < min_s);
        if (msat && v) res = (full > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return {res, c, v, (res == '0), res[W-1]};
    endfunction

    // Compare process: while out_valid, the DUT must show the oldest
    // outstanding expected result; it leaves the queue on an output transfer.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst !== 1'b0) begin
            exp_q.delete();
        end else begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = exp_q[0];
                    check("out_s", s, e[EW-1:4]);
                    check("out_flags", {cout, ovf, zero, neg}, e[3:0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub, sat_i));
        end
    end

    task automatic single_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                             input logic tsub, input logic tsat,
                             output logic [W-1:0] rs, output logic [3:0] rf, output int lat);
        @(posedge clk); #1;
        a = ta; b = tb; cin = tcin; sub = tsub; sat_i = tsat; in_valid = 1'b1;
        check("single_in_ready", in_ready, 1'b1);
        lat = 0;
        rs  = '0;
        rf  = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
            if (out_valid) begin
                rs = s;
                rf = {cout, ovf, zero, neg};
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] rs;
        logic [3:0]   rf;
        int           lat;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        sat_i = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_s", s, 32'h0);
        check("reset_flags", {cout, ovf, zero, neg}, 4'b0000);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", in_ready, 1'b1);

        // Pin the model to hand-computed values
        check("model_pin_ovf", model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0), {32'h8000_0000, 4'b0101});
        check("model_pin_borrow", model(32'h3, 32'h5, 1'b0, 1'b1, 1'b0), {32'hFFFF_FFFE, 4'b0001});

        // Directed cases with literal expectations
        single_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, rs, rf, lat);
        check("ovf_add_s", rs, 32'h8000_0000);
        check("ovf_add_flags", rf, 4'b0101);
        check("latency", lat, S);

        single_op(32'h5, 32'h5, 1'b1, 1'b1, 1'b0, rs, rf, lat);  // cin ignored on sub
        check("sub_zero_s", rs, 32'h0);
        check("sub_zero_flags", rf, 4'b1010);

        single_op(32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, rs, rf, lat);
        check("boundary_carry_s", rs, 32'h0001_0000);
        check("boundary_carry_flags", rf, 4'b0000);

        single_op(32'h3, 32'h5, 1'b0, 1'b1, 1'b0, rs, rf, lat);
        check("borrow_s", rs, 32'hFFFF_FFFE);
        check("borrow_flags", rf, 4'b0001);

        single_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, rs, rf, lat);
        check("wrap_s", rs, 32'h0);
        check("wrap_flags", rf, 4'b1010);

`ifdef ADDER_SAT_EN
        single_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, rs, rf, lat);
        check("sat_neg_s", rs, 32'h8000_0000);
        check("sat_neg_flags", rf, 4'b1101);
        single_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, rs, rf, lat);
        check("sat_pos_s", rs, 32'h7FFF_FFFF);
        check("sat_pos_flags", rf, 4'b0100);
        sat_i = 1'b0;
`endif

        // Backpressure: three back-to-back ops, out_ready low for 4 cycles
        @(posedge clk); #1;
        out_ready = 1'b0; a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'd10; b = 32'd20;
        check("bp_ready_c1", in_ready, 1'b1);
        @(posedge clk); #1;
        a = 32'd100; b = 32'd1; sub = 1'b1;
        check("bp_full_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_s_c2", s, 32'd3);
        @(posedge clk); #1;
        check("bp_s_c3", s, 32'd3);
        check("bp_ready_c3", in_ready, 1'b0);
        @(posedge clk); #1;
        check("bp_s_c4", s, 32'd3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; sub = 1'b0;
        check("bp_s_c5", s, 32'd30);
        @(posedge clk); #1;
        check("bp_s_c6", s, 32'd99);
        repeat (3) @(posedge clk);

        // Reset flush with two ops in flight
        #1;
        out_ready = 1'b0; a = 32'd7; b = 32'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_s", s, 32'h0);
        check("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("flush_no_output", out_valid, 1'b0);
        end

        // Random traffic with random backpressure and occasional reset
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            rst       = (cyc % 97 == 50);
            in_valid  = ($urandom_range(0, 99) < 70);
            a         = pick();
            b         = pick();
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
`ifdef ADDER_SAT_EN
            sat_i     = 1'($urandom_range(0, 1));
`endif
            out_ready = ($urandom_range(0, 99) < 70);
        end

        // Drain
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width; SHALL be a multiple of 4*STAGES.
REQ-002 Parameter STAGES, default 2: pipeline depth, legal range 1..4.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 in_valid  in  1  input operation present.
REQ-006 in_ready  out  1  pipeline accepts an operation this cycle.
REQ-007 a, b  in  WIDTH  operands, two's complement or unsigned.
REQ-008 cin  in  1  carry-in, used only when sub=0.
REQ-009 sub  in  1  1 selects a-b, 0 selects a+b+cin.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 s  out  WIDTH  sum or difference.
REQ-013 cout, ovf, zero, neg  out  1 each  carry-out, signed overflow, s==0, s[WIDTH-1].

Function
REQ-014 Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
REQ-015 Pipeline advance: advance = out_ready || !out_valid.
REQ-016 Stalling: in_ready SHALL equal advance; all stages hold contents when advance=0.
REQ-017 Slicing: stage k computes bits [(k+1)*W/STAGES-1 : k*W/STAGES] with 4-bit CLA groups; the slice carry-out is registered into stage k+1.
REQ-018 Operand skewing: upper operand slices SHALL be skew-registered alongside the data; lower sum slices SHALL be delay-registered to align at the output.
REQ-019 Latency: exactly STAGES cycles from input transfer to out_valid under no backpressure.
REQ-020 Throughput: one operation per cycle under no backpressure.
REQ-021 Subtract: sub=1 SHALL use ~b and carry-in 1, ignoring cin.
REQ-022 Carry-out: cout SHALL be the carry out of bit WIDTH-1; for subtraction cout=1 means no borrow.
REQ-023 Overflow: ovf SHALL be carry into MSB XOR carry out of MSB.
REQ-024 Flags: zero and neg SHALL be derived from the final s, after saturation when enabled.
REQ-025 Each stage SHALL carry a valid bit; bubbles SHALL propagate as valid=0.
REQ-026 Operations SHALL exit in acceptance order; none SHALL be dropped or duplicated.
REQ-027 Hold under stall: outputs SHALL be held stable while out_valid=1 and out_ready=0.
REQ-028 Simultaneous input and output transfer in one cycle SHALL be lossless.

Reset
REQ-029 While rst=1: all stage valid bits clear, out_valid=0, s=0, cout/ovf/zero/neg=0; in_ready SHALL read 1 on the cycle after rst deasserts.
REQ-030 Reset mid-operation SHALL discard every in-flight operation; no result is ever emitted for it.

Configuration
REQ-031 Macro ADDER_SAT_EN defined: adds input port sat (1 bit, in) that travels with the operation.
REQ-032 Saturation behaviour: with sat=1 and ovf=1, s SHALL clamp to the signed maximum (0x7FF..F) on positive overflow or the signed minimum (0x800..0) on negative overflow; ovf SHALL still report 1.
REQ-033 Macro ADDER_SAT_EN undefined: port sat and the clamp logic SHALL be absent, and s SHALL be the wrapped result.

Structure
REQ-034 Package adder_pkg SHALL hold: CLA_GROUP=4, MAX_STAGES=4, and the typedef for the flag struct {cout, ovf, zero, neg}.
REQ-035 Sub-module cla_group4 SHALL provide 4-bit lookahead carries plus group P/G, instantiated WIDTH/4 times; pipe_cla_adder owns all registers and the handshake.

Verification (WIDTH=32, STAGES=2)
REQ-036 Signed overflow on add: a=0x7FFFFFFF, b=1, sub=0, cin=0 -> 2 cycles later s=0x80000000, ovf=1, neg=1, cout=0.
REQ-037 Zero result on subtract: a=5, b=5, sub=1 -> s=0, zero=1, cout=1, ovf=0.
REQ-038 Carry across the stage boundary: a=0x0000FFFF, b=0, cin=1 -> s=0x00010000, cout=0.
REQ-039 Backpressure: three back-to-back ops with out_ready=0 for 4 cycles -> in_ready=0 once full, s held stable, the three results emerge in order after release.
REQ-040 Reset flush: rst asserted for 1 cycle with two ops in flight -> out_valid=0 the next cycle; neither result ever appears.
REQ-041 Saturation (ADDER_SAT_EN): a=0x80000000, b=1, sub=1, sat=1 -> s=0x80000000, ovf=1, neg=1.
